// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris game core.
// Holds the game command encoding, the horizontal auto-repeat state
// encoding, the USB keycode mapping and the playfield dimensions.
package tetris_pkg;

  typedef enum logic [2:0] {
    CMD_NONE      = 3'd0,
    CMD_LEFT      = 3'd1,
    CMD_RIGHT     = 3'd2,
    CMD_ROTATE    = 3'd3,
    CMD_DOWN      = 3'd4,
    CMD_HARD_DROP = 3'd5
  } cmd_t;

  typedef enum logic [1:0] {
    H_IDLE   = 2'd0,
    H_DAS    = 2'd1,
    H_REPEAT = 2'd2
  } hstate_t;

  localparam logic [7:0] KEY_LEFT  = 8'h04;  // A
  localparam logic [7:0] KEY_RIGHT = 8'h07;  // D
  localparam logic [7:0] KEY_ROT   = 8'h1A;  // W
  localparam logic [7:0] KEY_DOWN  = 8'h16;  // S
  localparam logic [7:0] KEY_DROP  = 8'h2C;  // space

  localparam int GRID_W = 10;
  localparam int GRID_H = 22;

endpackage

// File: rtl/key_repeat_fsm.sv
// Horizontal delayed-auto-shift / auto-repeat state machine.
// Ports:
//   frame_clk, Reset : frame clock, synchronous active-high reset
//   enable           : game running; when low the machine is held in IDLE
//   keycode          : current raw keycode
//   press_edge       : keycode is mapped and differs from last frame's keycode
//   emit             : one-frame strobe, a horizontal command is due this frame
//   dir              : direction of the command (valid while emit is high)
// emit/dir are decided from this frame's inputs so the command can be loaded
// into the output register on the same edge that samples the key.
module key_repeat_fsm
  import tetris_pkg::*;
#(
  parameter int         DAS_DELAY  = 10,
  parameter int         ARR_PERIOD = 3,
  parameter logic [7:0] LEFT_CODE  = tetris_pkg::KEY_LEFT,
  parameter logic [7:0] RIGHT_CODE = tetris_pkg::KEY_RIGHT
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       enable,
  input  logic [7:0] keycode,
  input  logic       press_edge,
  output logic       emit,
  output cmd_t       dir
);

  localparam logic [7:0] DAS_LAST = 8'(DAS_DELAY - 1);
  localparam logic [7:0] ARR_LAST = 8'(ARR_PERIOD - 1);

  hstate_t    state, state_next;
  cmd_t       dir_q, dir_next;
  logic [7:0] cnt, cnt_next;
  logic [7:0] latched_key;
  logic       is_horiz;
  logic       held;

  assign latched_key = (dir_q == CMD_LEFT) ? LEFT_CODE : RIGHT_CODE;
  assign is_horiz    = (keycode == LEFT_CODE) || (keycode == RIGHT_CODE);
  assign held        = (state != H_IDLE) && (keycode == latched_key);
  assign dir         = dir_next;

  // Any keycode other than the latched key drops back to IDLE in the same
  // frame, and an opposite horizontal key is evaluated as a fresh press.
  always_comb begin
    state_next = state;
    dir_next   = dir_q;
    cnt_next   = cnt;
    emit       = 1'b0;
    if (!enable) begin
      state_next = H_IDLE;
      cnt_next   = 8'd0;
    end else if (held) begin
      if (state == H_DAS) begin
        if (cnt == DAS_LAST) begin
          emit       = 1'b1;
          cnt_next   = 8'd0;
          state_next = H_REPEAT;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end else begin
        if (cnt == ARR_LAST) begin
          emit     = 1'b1;
          cnt_next = 8'd0;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
    end else if (is_horiz && press_edge) begin
      emit       = 1'b1;
      dir_next   = (keycode == LEFT_CODE) ? CMD_LEFT : CMD_RIGHT;
      cnt_next   = 8'd0;
      state_next = H_DAS;
    end else begin
      state_next = H_IDLE;
      cnt_next   = 8'd0;
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state <= H_IDLE;
      dir_q <= CMD_LEFT;
      cnt   <= 8'd0;
    end else begin
      state <= state_next;
      dir_q <= dir_next;
      cnt   <= cnt_next;
    end
  end

endmodule

// File: rtl/key_cmd_gen.sv
// Input conditioner for the Tetris core: turns the per-frame USB keycode
// into a stream of game commands with DAS/ARR on horizontal keys, merges in
// a gravity timer and hands out one command at a time on valid/ready.
// Ports:
//   frame_clk, Reset : frame clock, synchronous active-high reset
//   enable           : game running; when low the block is inert
//   keycode          : current USB keycode (8'h00 or unmapped = no key)
//   cmd_ready        : consumer accepts the presented command
//   cmd_valid, cmd   : presented command, stable until accepted
//   drop_count       : key commands discarded due to an occupied slot (saturating)
// Parameters must lie in 1..255 since all counters are 8 bits.
module key_cmd_gen
  import tetris_pkg::*;
#(
  parameter int         DAS_DELAY   = 10,
  parameter int         ARR_PERIOD  = 3,
  parameter int         GRAV_PERIOD = 20,
  parameter int         SOFT_PERIOD = 2,
  parameter logic [7:0] KEY_LEFT    = tetris_pkg::KEY_LEFT,
  parameter logic [7:0] KEY_RIGHT   = tetris_pkg::KEY_RIGHT,
  parameter logic [7:0] KEY_ROT     = tetris_pkg::KEY_ROT,
  parameter logic [7:0] KEY_DOWN    = tetris_pkg::KEY_DOWN,
  parameter logic [7:0] KEY_DROP    = tetris_pkg::KEY_DROP
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       enable,
  input  logic [7:0] keycode,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output cmd_t       cmd,
  output logic [7:0] drop_count
);

  localparam logic [7:0] GRAV_LAST = 8'(GRAV_PERIOD - 1);
  localparam logic [7:0] SOFT_LAST = 8'(SOFT_PERIOD - 1);

  logic [7:0] prev_keycode;
  logic [7:0] grav_cnt, grav_cnt_next, grav_last;
  logic       grav_pending;
  logic       grav_evt;
  logic       mapped, press_edge, slot_free;
  logic       h_emit;
  cmd_t       h_dir;
  cmd_t       key_cmd;

  assign mapped     = (keycode == KEY_LEFT) || (keycode == KEY_RIGHT) ||
                      (keycode == KEY_ROT)  || (keycode == KEY_DOWN)  ||
                      (keycode == KEY_DROP);
  assign press_edge = mapped && (keycode != prev_keycode);
  assign slot_free  = !cmd_valid || cmd_ready;
  assign grav_last  = (keycode == KEY_DOWN) ? SOFT_LAST : GRAV_LAST;

  key_repeat_fsm #(
    .DAS_DELAY (DAS_DELAY),
    .ARR_PERIOD(ARR_PERIOD),
    .LEFT_CODE (KEY_LEFT),
    .RIGHT_CODE(KEY_RIGHT)
  ) u_repeat (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .enable    (enable),
    .keycode   (keycode),
    .press_edge(press_edge),
    .emit      (h_emit),
    .dir       (h_dir)
  );

  // Only one keycode exists per frame, so at most one of these can be live;
  // the ordering still documents the intended priority.
  always_comb begin
    key_cmd = CMD_NONE;
    if (enable) begin
      if (press_edge && keycode == KEY_DROP)     key_cmd = CMD_HARD_DROP;
      else if (press_edge && keycode == KEY_ROT) key_cmd = CMD_ROTATE;
      else if (h_emit)                           key_cmd = h_dir;
    end
  end

  // A down press restarts the timer with an immediate step; a down release
  // restarts it silently so normal gravity resumes a full period later.
  always_comb begin
    grav_evt      = 1'b0;
    grav_cnt_next = grav_cnt;
    if (!enable) begin
      grav_cnt_next = 8'd0;
    end else if (press_edge && keycode == KEY_DOWN) begin
      grav_evt      = 1'b1;
      grav_cnt_next = 8'd0;
    end else if (prev_keycode == KEY_DOWN && keycode != KEY_DOWN) begin
      grav_cnt_next = 8'd0;
    end else if (grav_cnt == grav_last) begin
      grav_evt      = 1'b1;
      grav_cnt_next = 8'd0;
    end else begin
      grav_cnt_next = grav_cnt + 8'd1;
    end
  end

  // Keys beat gravity for the slot; a gravity step that cannot load is kept
  // as a single sticky pending flag, while a key that cannot load is dropped.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      prev_keycode <= 8'd0;
      grav_cnt     <= 8'd0;
      grav_pending <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd          <= CMD_NONE;
      drop_count   <= 8'd0;
    end else begin
      prev_keycode <= keycode;
      grav_cnt     <= grav_cnt_next;
      if (!enable) begin
        cmd_valid    <= 1'b0;
        cmd          <= CMD_NONE;
        grav_pending <= 1'b0;
      end else if (slot_free) begin
        if (key_cmd != CMD_NONE) begin
          cmd_valid <= 1'b1;
          cmd       <= key_cmd;
          if (grav_evt) grav_pending <= 1'b1;
        end else if (grav_evt || grav_pending) begin
          cmd_valid    <= 1'b1;
          cmd          <= CMD_DOWN;
          grav_pending <= 1'b0;
        end else begin
          cmd_valid <= 1'b0;
          cmd       <= CMD_NONE;
        end
      end else begin
        if (key_cmd != CMD_NONE && drop_count != 8'hFF)
          drop_count <= drop_count + 8'd1;
        if (grav_evt) grav_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_key_cmd_gen.sv
// Directed testbench for key_cmd_gen with default parameters.
// Edge numbering: edge 1 is the first rising edge with Reset low after a
// reset edge. Observed command = cmd when cmd_valid, else CMD_NONE.
module tb_key_cmd_gen;
  import tetris_pkg::*;

  logic       frame_clk;
  logic       Reset;
  logic       enable;
  logic [7:0] keycode;
  logic       cmd_ready;
  logic       cmd_valid;
  cmd_t       cmd;
  logic [7:0] drop_count;

  int checks = 0;
  int errors = 0;

  key_cmd_gen dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .enable    (enable),
    .keycode   (keycode),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .drop_count(drop_count)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic check_output(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after an edge, then the next edge is taken
  // and outputs are sampled 1 time unit after it.
  task automatic apply_stimulus(input logic [7:0] kc, input logic rdy,
                                input logic en, input logic rst);
    keycode   = kc;
    cmd_ready = rdy;
    enable    = en;
    Reset     = rst;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    apply_stimulus(8'h00, 1'b1, 1'b1, 1'b1);
  endtask

  function automatic logic [7:0] observed_cmd();
    return cmd_valid ? 8'(cmd) : 8'(CMD_NONE);
  endfunction

  cmd_t       exp_cmd;
  logic [7:0] kc;

  initial begin
    keycode   = 8'h00;
    cmd_ready = 1'b1;
    enable    = 1'b1;
    Reset     = 1'b1;
    #1;

    // Reset values
    do_reset();
    check_output("reset cmd_valid", {7'd0, cmd_valid}, 8'd0);
    check_output("reset cmd", 8'(cmd), 8'(CMD_NONE));
    check_output("reset drop_count", drop_count, 8'd0);

    // Taps: A at 5, space at 8, W at 10; first gravity at 20
    for (int e = 1; e <= 21; e++) begin
      kc = (e == 5) ? KEY_LEFT : (e == 8) ? KEY_DROP : (e == 10) ? KEY_ROT : 8'h00;
      apply_stimulus(kc, 1'b1, 1'b1, 1'b0);
      exp_cmd = (e == 5)  ? CMD_LEFT :
                (e == 8)  ? CMD_HARD_DROP :
                (e == 10) ? CMD_ROTATE :
                (e == 20) ? CMD_DOWN : CMD_NONE;
      check_output($sformatf("tap e%0d", e), observed_cmd(), 8'(exp_cmd));
    end

    // Hold D: RIGHT at 1, 11, 14, 17, 20; gravity loses at 20 -> DOWN at 21
    do_reset();
    for (int e = 1; e <= 22; e++) begin
      apply_stimulus(KEY_RIGHT, 1'b1, 1'b1, 1'b0);
      exp_cmd = (e == 1 || e == 11 || e == 14 || e == 17 || e == 20) ? CMD_RIGHT :
                (e == 21) ? CMD_DOWN : CMD_NONE;
      check_output($sformatf("holdD e%0d", e), observed_cmd(), 8'(exp_cmd));
    end

    // Backpressure: LEFT held in slot, W dropped, gravity pending until 25
    do_reset();
    for (int e = 1; e <= 26; e++) begin
      kc = (e == 1) ? KEY_LEFT : (e == 3) ? KEY_ROT : 8'h00;
      apply_stimulus(kc, (e >= 25), 1'b1, 1'b0);
      exp_cmd = (e <= 24) ? CMD_LEFT : (e == 25) ? CMD_DOWN : CMD_NONE;
      check_output($sformatf("bp e%0d", e), observed_cmd(), 8'(exp_cmd));
      if (e == 2)  check_output("bp drop_count e2", drop_count, 8'd0);
      if (e == 3)  check_output("bp drop_count e3", drop_count, 8'd1);
      if (e == 26) check_output("bp drop_count e26", drop_count, 8'd1);
    end

    // Hold S on edges 5..11: soft drops at 5, 7, 9, 11; release at 12 -> next at 32
    do_reset();
    for (int e = 1; e <= 33; e++) begin
      kc = (e >= 5 && e <= 11) ? KEY_DOWN : 8'h00;
      apply_stimulus(kc, 1'b1, 1'b1, 1'b0);
      exp_cmd = (e == 5 || e == 7 || e == 9 || e == 11 || e == 32) ? CMD_DOWN : CMD_NONE;
      check_output($sformatf("holdS e%0d", e), observed_cmd(), 8'(exp_cmd));
    end

    // Opposite key mid-DAS: A on 1..5, then D -> RIGHT at 6 and repeat at 16
    do_reset();
    for (int e = 1; e <= 17; e++) begin
      kc = (e <= 5) ? KEY_LEFT : KEY_RIGHT;
      apply_stimulus(kc, 1'b1, 1'b1, 1'b0);
      exp_cmd = (e == 1) ? CMD_LEFT : (e == 6 || e == 16) ? CMD_RIGHT : CMD_NONE;
      check_output($sformatf("swap e%0d", e), observed_cmd(), 8'(exp_cmd));
    end

    // Reset mid-hold: A held, ready low until reset at 12 so a repeat is dropped
    do_reset();
    for (int e = 1; e <= 24; e++) begin
      apply_stimulus(KEY_LEFT, (e >= 12), 1'b1, (e == 12));
      exp_cmd = (e <= 11 || e == 13 || e == 23) ? CMD_LEFT : CMD_NONE;
      check_output($sformatf("rsthold e%0d", e), observed_cmd(), 8'(exp_cmd));
      if (e == 11) check_output("rsthold drop_count e11", drop_count, 8'd1);
      if (e == 12) check_output("rsthold drop_count e12", drop_count, 8'd0);
      if (e == 12) check_output("rsthold cmd e12", 8'(cmd), 8'(CMD_NONE));
    end

    // enable low on edges 3..30 with keys pressed; gravity restarts -> DOWN at 50
    do_reset();
    for (int e = 1; e <= 51; e++) begin
      kc = (e == 10) ? KEY_LEFT : (e >= 15 && e <= 20) ? KEY_RIGHT :
           (e == 25) ? KEY_ROT : (e == 28) ? KEY_DROP : 8'h00;
      apply_stimulus(kc, 1'b1, !(e >= 3 && e <= 30), 1'b0);
      exp_cmd = (e == 50) ? CMD_DOWN : CMD_NONE;
      check_output($sformatf("enable e%0d", e), observed_cmd(), 8'(exp_cmd));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
